// File: rtl/countdown_pkg.sv
// Shared types and helpers for the loadable multi-digit countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The prescaler is sized for the default 1 s tick at 50 MHz. Any divider
    // up to this value fits. A larger divider needs this width raised.
    localparam int unsigned TICK_DIV_MAX = 50_000_000;
    localparam int          PRESC_W      = $clog2(TICK_DIV_MAX);

    // A loaded digit value outside 0..radix-1 is forced to radix-1.
    function automatic int unsigned clamp_digit(input int unsigned value,
                                                input int unsigned radix);
        return (value >= radix) ? radix - 1 : value;
    endfunction

endpackage

// File: rtl/countdown_timer_mod_n_down.sv
// One mod-N down-counting digit; borrow_o enables the next more significant digit.
module mod_n_down
    import countdown_pkg::*;
#(
    parameter int DW = 4,
    parameter int N  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] load_value_i,
    input  logic          enable_i,
    output logic [DW-1:0] count_o,
    output logic          borrow_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_o <= '0;
        end else if (load_i) begin
            count_o <= DW'(clamp_digit(32'(load_value_i), N));
        end else if (enable_i) begin
            count_o <= (count_o == '0) ? DW'(N - 1) : count_o - DW'(1);
        end
    end

    // A digit at zero that is asked to decrement wraps and borrows upward.
    assign borrow_o = enable_i & (count_o == '0);

endmodule

// File: rtl/countdown_timer.sv
// Multi-digit down-counter with tick prescaler and IDLE/RUN/PAUSE/DONE control.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DW       = 4,
    parameter int N        = 10,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                 clk_50MHz_i,
    input  logic                 rst_sync_i,
    input  logic                 load_i,
    input  logic [DIGITS*DW-1:0] load_value_i,
    input  logic                 start_i,
    input  logic                 pause_i,
    output logic [DIGITS*DW-1:0] count_o,
    output logic                 running_o,
    output logic                 expired_o,
    output logic                 expired_pulse_o
);

    state_t               state, state_n;
    logic [PRESC_W-1:0]   presc, presc_n;
    logic                 pulse_n;
    logic                 tick;
    logic                 tick_en;
    logic                 count_zero;
    logic                 last_tick;
    logic [DIGITS:0]      enable_chain;
    logic                 unused_borrow;

    assign tick       = (presc == PRESC_W'(TICK_DIV - 1));
    assign count_zero = (count_o == '0);
    // Digit 0 at 1 with every higher digit at 0: the next tick reaches zero.
    assign last_tick  = (count_o == (DIGITS*DW)'(1));

    always_comb begin
        state_n = state;
        presc_n = presc;
        pulse_n = 1'b0;
        tick_en = 1'b0;
        if (load_i) begin
            state_n = IDLE;
            presc_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (count_zero) begin
                            state_n = DONE;
                            pulse_n = 1'b1;
                        end else begin
                            state_n = RUN;
                            presc_n = '0;
                        end
                    end
                end
                RUN: begin
                    // Pause beats a coincident tick; the prescaler holds at TICK_DIV-1
                    // so the lost tick fires on the first cycle after resume.
                    if (pause_i) begin
                        state_n = PAUSE;
                    end else if (tick) begin
                        tick_en = 1'b1;
                        presc_n = '0;
                        if (last_tick) begin
                            state_n = DONE;
                            pulse_n = 1'b1;
                        end
                    end else begin
                        presc_n = presc + PRESC_W'(1);
                    end
                end
                PAUSE: begin
                    if (start_i) state_n = RUN;
                end
                DONE: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_i) begin
            state           <= IDLE;
            presc           <= '0;
            running_o       <= 1'b0;
            expired_o       <= 1'b0;
            expired_pulse_o <= 1'b0;
        end else begin
            state           <= state_n;
            presc           <= presc_n;
            running_o       <= (state_n == RUN);
            expired_o       <= (state_n == DONE);
            expired_pulse_o <= pulse_n;
        end
    end

    assign enable_chain[0] = tick_en;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            mod_n_down #(
                .DW (DW),
                .N  (N)
            ) u_digit (
                .clk          (clk_50MHz_i),
                .rst          (rst_sync_i),
                .load_i       (load_i),
                .load_value_i (load_value_i[k*DW +: DW]),
                .enable_i     (enable_chain[k]),
                .count_o      (count_o[k*DW +: DW]),
                .borrow_o     (enable_chain[k+1])
            );
        end
    endgenerate

    // The top digit's borrow never fires: DONE is entered before the count could wrap.
    assign unused_borrow = enable_chain[DIGITS];

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with DIGITS=2, N=10, TICK_DIV=4.
module tb_countdown_timer;

    localparam int DIGITS   = 2;
    localparam int DW       = 4;
    localparam int N        = 10;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  load_value = 8'h00;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [7:0]  count;
    logic        running;
    logic        expired;
    logic        pulse;
    logic [10:0] obs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign obs = {count, running, expired, pulse};

    countdown_timer #(
        .DIGITS   (DIGITS),
        .DW       (DW),
        .N        (N),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk_50MHz_i     (clk),
        .rst_sync_i      (rst),
        .load_i          (load),
        .load_value_i    (load_value),
        .start_i         (start),
        .pause_i         (pause),
        .count_o         (count),
        .running_o       (running),
        .expired_o       (expired),
        .expired_pulse_o (pulse)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_value = v;
        tick(1);
        load = 1'b0;
        load_value = 8'h00;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        tests++;
        if (obs !== 11'h000) begin
            fails++;
            $display("FAIL reset: {count,run,exp,pulse} got %h expected %h", obs, 11'h000);
        end
        rst = 1'b0;
        tick(1);
        tests++;
        if (obs !== 11'h000) begin
            fails++;
            $display("FAIL reset_release: got %h expected %h", obs, 11'h000);
        end
    endtask

    task automatic test_countdown();
        do_load(8'h12);
        tests++;
        if (obs !== {8'h12, 3'b000}) begin
            fails++;
            $display("FAIL load_12: got %h expected %h", obs, {8'h12, 3'b000});
        end
        do_start();
        tests++;
        if (obs !== {8'h12, 3'b100}) begin
            fails++;
            $display("FAIL start_running: got %h expected %h", obs, {8'h12, 3'b100});
        end
        tick(3);
        tests++;
        if (obs !== {8'h12, 3'b100}) begin
            fails++;
            $display("FAIL before_first_tick: got %h expected %h", obs, {8'h12, 3'b100});
        end
        tick(1);
        tests++;
        if (obs !== {8'h11, 3'b100}) begin
            fails++;
            $display("FAIL first_tick: got %h expected %h", obs, {8'h11, 3'b100});
        end
        tick(16);
        tests++;
        if (obs !== {8'h07, 3'b100}) begin
            fails++;
            $display("FAIL fifth_tick: got %h expected %h", obs, {8'h07, 3'b100});
        end
        tick(27);
        tests++;
        if (obs !== {8'h01, 3'b100}) begin
            fails++;
            $display("FAIL before_expire: got %h expected %h", obs, {8'h01, 3'b100});
        end
        tick(1);
        tests++;
        if (obs !== {8'h00, 3'b011}) begin
            fails++;
            $display("FAIL expire_edge: got %h expected %h", obs, {8'h00, 3'b011});
        end
        tick(1);
        tests++;
        if (obs !== {8'h00, 3'b010}) begin
            fails++;
            $display("FAIL pulse_one_cycle: got %h expected %h", obs, {8'h00, 3'b010});
        end
        start = 1'b1;
        pause = 1'b1;
        tick(1);
        start = 1'b0;
        pause = 1'b0;
        tests++;
        if (obs !== {8'h00, 3'b010}) begin
            fails++;
            $display("FAIL done_ignores_start: got %h expected %h", obs, {8'h00, 3'b010});
        end
    endtask

    task automatic test_borrow();
        do_load(8'h10);
        tests++;
        if (obs !== {8'h10, 3'b000}) begin
            fails++;
            $display("FAIL load_from_done: got %h expected %h", obs, {8'h10, 3'b000});
        end
        do_start();
        tick(4);
        tests++;
        if (obs !== {8'h09, 3'b100}) begin
            fails++;
            $display("FAIL borrow_10: got %h expected %h", obs, {8'h09, 3'b100});
        end
        do_load(8'h20);
        do_start();
        tick(4);
        tests++;
        if (obs !== {8'h19, 3'b100}) begin
            fails++;
            $display("FAIL borrow_20: got %h expected %h", obs, {8'h19, 3'b100});
        end
        tick(40);
        tests++;
        if (obs !== {8'h09, 3'b100}) begin
            fails++;
            $display("FAIL borrow_second: got %h expected %h", obs, {8'h09, 3'b100});
        end
    endtask

    task automatic test_pause();
        do_load(8'h05);
        do_start();
        tick(4);
        tests++;
        if (obs !== {8'h04, 3'b100}) begin
            fails++;
            $display("FAIL pause_pre_tick: got %h expected %h", obs, {8'h04, 3'b100});
        end
        tick(2);
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (obs !== {8'h04, 3'b000}) begin
                fails++;
                $display("FAIL pause_hold[%0d]: got %h expected %h", i, obs, {8'h04, 3'b000});
            end
            tick(1);
        end
        do_start();
        tests++;
        if (obs !== {8'h04, 3'b100}) begin
            fails++;
            $display("FAIL resume: got %h expected %h", obs, {8'h04, 3'b100});
        end
        tick(1);
        tests++;
        if (obs !== {8'h04, 3'b100}) begin
            fails++;
            $display("FAIL resume_plus1: got %h expected %h", obs, {8'h04, 3'b100});
        end
        tick(1);
        tests++;
        if (obs !== {8'h03, 3'b100}) begin
            fails++;
            $display("FAIL resume_plus2: got %h expected %h", obs, {8'h03, 3'b100});
        end
        // Pause exactly on a tick cycle: the tick is lost and fires right after resume.
        tick(3);
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        tests++;
        if (obs !== {8'h03, 3'b000}) begin
            fails++;
            $display("FAIL pause_on_tick: got %h expected %h", obs, {8'h03, 3'b000});
        end
        do_start();
        tests++;
        if (obs !== {8'h03, 3'b100}) begin
            fails++;
            $display("FAIL resume_held_tick: got %h expected %h", obs, {8'h03, 3'b100});
        end
        tick(1);
        tests++;
        if (obs !== {8'h02, 3'b100}) begin
            fails++;
            $display("FAIL lost_tick_fires: got %h expected %h", obs, {8'h02, 3'b100});
        end
    endtask

    task automatic test_clamp_zero();
        do_load(8'hAF);
        tests++;
        if (obs !== {8'h99, 3'b000}) begin
            fails++;
            $display("FAIL clamp_af: got %h expected %h", obs, {8'h99, 3'b000});
        end
        load = 1'b1;
        start = 1'b1;
        load_value = 8'h45;
        tick(1);
        load = 1'b0;
        start = 1'b0;
        load_value = 8'h00;
        tests++;
        if (obs !== {8'h45, 3'b000}) begin
            fails++;
            $display("FAIL load_beats_start: got %h expected %h", obs, {8'h45, 3'b000});
        end
        do_load(8'h00);
        do_start();
        tests++;
        if (obs !== {8'h00, 3'b011}) begin
            fails++;
            $display("FAIL zero_start: got %h expected %h", obs, {8'h00, 3'b011});
        end
        tick(1);
        tests++;
        if (obs !== {8'h00, 3'b010}) begin
            fails++;
            $display("FAIL zero_start_done: got %h expected %h", obs, {8'h00, 3'b010});
        end
    endtask

    task automatic test_interrupts();
        do_load(8'h50);
        do_start();
        tick(5);
        tests++;
        if (obs !== {8'h49, 3'b100}) begin
            fails++;
            $display("FAIL run_50: got %h expected %h", obs, {8'h49, 3'b100});
        end
        do_load(8'h37);
        tests++;
        if (obs !== {8'h37, 3'b000}) begin
            fails++;
            $display("FAIL load_mid_run: got %h expected %h", obs, {8'h37, 3'b000});
        end
        tick(4);
        tests++;
        if (obs !== {8'h37, 3'b000}) begin
            fails++;
            $display("FAIL idle_after_load: got %h expected %h", obs, {8'h37, 3'b000});
        end
        do_start();
        tick(2);
        rst = 1'b1;
        tick(1);
        tests++;
        if (obs !== 11'h000) begin
            fails++;
            $display("FAIL reset_mid_run: got %h expected %h", obs, 11'h000);
        end
        rst = 1'b0;
        tick(5);
        tests++;
        if (obs !== 11'h000) begin
            fails++;
            $display("FAIL after_reset_idle: got %h expected %h", obs, 11'h000);
        end
        do_load(8'h01);
        do_start();
        tick(3);
        tests++;
        if (obs !== {8'h01, 3'b100}) begin
            fails++;
            $display("FAIL pre_final: got %h expected %h", obs, {8'h01, 3'b100});
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++;
        if (obs !== 11'h000) begin
            fails++;
            $display("FAIL reset_on_final: got %h expected %h", obs, 11'h000);
        end
        tick(1);
        tests++;
        if (obs !== 11'h000) begin
            fails++;
            $display("FAIL no_late_pulse: got %h expected %h", obs, 11'h000);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_clamp_zero();
        test_interrupts();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
